// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: control codes, state encoding
// and the legal-op check used when ALU_OPCHECK_EN is defined.
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } arb_state_t;

   function automatic logic alu_op_legal(input logic [2:0] ctrl);
      return (ctrl == ALU_AND) || (ctrl == ALU_OR) || (ctrl == ALU_ADD) ||
             (ctrl == ALU_SUB) || (ctrl == ALU_SLT);
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker. A lone valid requester always wins; when both
// are valid the pointer decides. Output is one-hot (or zero when idle).
module rr_pick2 (
   input  logic [1:0] i_valid,
   input  logic       i_ptr,
   output logic [1:0] o_grant
);

   // Pointer only matters on contention.
   always_comb begin
      o_grant = i_valid;
      if (i_valid == 2'b11) begin
         o_grant = i_ptr ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates the single execute-stage ALU between the main execute path (r0)
// and the branch/compare helper (r1). One op in flight at a time:
// IDLE -> EXEC -> RESP. Optional macro ALU_OPCHECK_EN adds rsp_err and
// short-circuits illegal control codes straight to RESP.
//
//   state | meaning
//   IDLE  | accepting a request, alu_* registers held
//   EXEC  | ALU evaluating registered operands, result captured at edge
//   RESP  | response held for owner until its rsp_ready
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic [WIDTH-1:0]  r0_a,
   input  logic [WIDTH-1:0]  r0_b,
   input  logic [CTRL_W-1:0] r0_control,
   output logic              r0_rsp_valid,
   input  logic              r0_rsp_ready,
   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic [WIDTH-1:0]  r1_a,
   input  logic [WIDTH-1:0]  r1_b,
   input  logic [CTRL_W-1:0] r1_control,
   output logic              r1_rsp_valid,
   input  logic              r1_rsp_ready,
   output logic [WIDTH-1:0]  rsp_result,
   output logic              rsp_zero,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [CTRL_W-1:0] alu_control,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic              alu_zero
`ifdef ALU_OPCHECK_EN
   ,
   output logic              rsp_err
`endif
);

   arb_state_t        r_state;
   logic              r_ptr;
   logic              r_owner;
   logic [1:0]        r_rsp_valid;
   logic [WIDTH-1:0]  r_rsp_result;
   logic              r_rsp_zero;
   logic [WIDTH-1:0]  r_alu_a;
   logic [WIDTH-1:0]  r_alu_b;
   logic [CTRL_W-1:0] r_alu_control;

   logic [1:0]        w_grant;
   logic              w_idle;
   logic              w_hs;
   logic              w_winner;
   logic [WIDTH-1:0]  w_a;
   logic [WIDTH-1:0]  w_b;
   logic [CTRL_W-1:0] w_ctrl;
   logic [1:0]        w_rsp_ready;

   rr_pick2 u_pick (
      .i_valid (({r1_valid, r0_valid})),
      .i_ptr   (r_ptr),
      .o_grant (w_grant)
   );

   assign w_idle      = (r_state == ST_IDLE);
   assign r0_ready    = w_idle & w_grant[0];
   assign r1_ready    = w_idle & w_grant[1];
   assign w_hs        = r0_ready | r1_ready;
   assign w_winner    = w_grant[1];
   assign w_a         = w_winner ? r1_a       : r0_a;
   assign w_b         = w_winner ? r1_b       : r0_b;
   assign w_ctrl      = w_winner ? r1_control : r0_control;
   assign w_rsp_ready = {r1_rsp_ready, r0_rsp_ready};

   assign r0_rsp_valid = r_rsp_valid[0];
   assign r1_rsp_valid = r_rsp_valid[1];
   assign rsp_result   = r_rsp_result;
   assign rsp_zero     = r_rsp_zero;
   assign alu_a        = r_alu_a;
   assign alu_b        = r_alu_b;
   assign alu_control  = r_alu_control;

`ifdef ALU_OPCHECK_EN
   logic r_rsp_err;
   assign rsp_err = r_rsp_err;
`endif

   // Arbiter FSM with registered operand, response and pointer state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_ptr         <= 1'b0;
         r_owner       <= 1'b0;
         r_rsp_valid   <= 2'b00;
         r_rsp_result  <= '0;
         r_rsp_zero    <= 1'b0;
         r_alu_a       <= '0;
         r_alu_b       <= '0;
         r_alu_control <= CTRL_W'(ALU_ADD);
`ifdef ALU_OPCHECK_EN
         r_rsp_err     <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_hs) begin
                  r_owner <= w_winner;
`ifdef ALU_OPCHECK_EN
                  if (!alu_op_legal(w_ctrl)) begin
                     // Illegal op never reaches the ALU; answer with an error.
                     r_rsp_result <= '0;
                     r_rsp_zero   <= 1'b0;
                     r_rsp_err    <= 1'b1;
                     r_rsp_valid  <= w_winner ? 2'b10 : 2'b01;
                     r_state      <= ST_RESP;
                  end else begin
                     r_alu_a       <= w_a;
                     r_alu_b       <= w_b;
                     r_alu_control <= w_ctrl;
                     r_rsp_err     <= 1'b0;
                     r_state       <= ST_EXEC;
                  end
`else
                  r_alu_a       <= w_a;
                  r_alu_b       <= w_b;
                  r_alu_control <= w_ctrl;
                  r_state       <= ST_EXEC;
`endif
               end
            end
            ST_EXEC: begin
               r_rsp_result <= alu_result;
               r_rsp_zero   <= alu_zero;
               r_rsp_valid  <= r_owner ? 2'b10 : 2'b01;
               r_state      <= ST_RESP;
            end
            ST_RESP: begin
               if (w_rsp_ready[r_owner]) begin
                  r_rsp_valid <= 2'b00;
                  r_ptr       <= ~r_owner;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_rsp_valid <= 2'b00;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the alu_* bus.
// Covers ALU_OPCHECK_EN when the macro is defined for the build.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
   logic [31:0] r0_a, r0_b;
   logic [2:0]  r0_control;
   logic        r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
   logic [31:0] r1_a, r1_b;
   logic [2:0]  r1_control;
   logic [31:0] rsp_result, alu_a, alu_b, alu_result;
   logic        rsp_zero, alu_zero;
   logic [2:0]  alu_control;
`ifdef ALU_OPCHECK_EN
   logic        rsp_err;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(32), .CTRL_W(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .r0_valid     (r0_valid),
      .r0_ready     (r0_ready),
      .r0_a         (r0_a),
      .r0_b         (r0_b),
      .r0_control   (r0_control),
      .r0_rsp_valid (r0_rsp_valid),
      .r0_rsp_ready (r0_rsp_ready),
      .r1_valid     (r1_valid),
      .r1_ready     (r1_ready),
      .r1_a         (r1_a),
      .r1_b         (r1_b),
      .r1_control   (r1_control),
      .r1_rsp_valid (r1_rsp_valid),
      .r1_rsp_ready (r1_rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_zero     (rsp_zero),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_control  (alu_control),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero)
`ifdef ALU_OPCHECK_EN
      ,
      .rsp_err      (rsp_err)
`endif
   );

   // Behavioural ALU sitting on the arbiter's alu_* bus.
   always_comb begin
      alu_result = 32'd0;
      case (alu_control)
         3'b000:  alu_result = alu_a & alu_b;
         3'b001:  alu_result = alu_a | alu_b;
         3'b010:  alu_result = alu_a + alu_b;
         3'b110:  alu_result = alu_a - alu_b;
         3'b111:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         default: alu_result = 32'd0;
      endcase
      alu_zero = (alu_result == 32'd0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      r0_valid = 0; r0_a = 0; r0_b = 0; r0_control = 0; r0_rsp_ready = 1;
      r1_valid = 0; r1_a = 0; r1_b = 0; r1_control = 0; r1_rsp_ready = 1;
      step();
      step();
      rst = 1'b0;
      #1;
      n_tests++;
      if (r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_rsp_valid got=%b%b exp=00", r1_rsp_valid, r0_rsp_valid);
      end
      n_tests++;
      if (rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin
         n_fail++; $display("FAIL reset_rsp got=%0d/%b exp=0/0", rsp_result, rsp_zero);
      end
      n_tests++;
      if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_control !== 3'b010) begin
         n_fail++; $display("FAIL reset_alu got=%0d/%0d/%b exp=0/0/010", alu_a, alu_b, alu_control);
      end
      n_tests++;
      if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready got=%b%b exp=00", r1_ready, r0_ready);
      end
   endtask

   task automatic test_single();
      r0_valid = 1; r0_a = 5; r0_b = 3; r0_control = 3'b010;
      #1;
      n_tests++;
      if (r0_ready !== 1'b1) begin
         n_fail++; $display("FAIL single_ready got=%b exp=1", r0_ready);
      end
      step();
      r0_valid = 0;
      n_tests++;
      if (alu_a !== 32'd5 || alu_b !== 32'd3 || r0_rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_exec got a=%0d b=%0d rv=%b exp 5 3 0", alu_a, alu_b, r0_rsp_valid);
      end
      step();
      n_tests++;
      if (r0_rsp_valid !== 1'b1 || rsp_result !== 32'd8 || rsp_zero !== 1'b0) begin
         n_fail++; $display("FAIL single_rsp got rv=%b res=%0d z=%b exp 1 8 0", r0_rsp_valid, rsp_result, rsp_zero);
      end
      step();
      n_tests++;
      if (r0_rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_release got=%b exp=0", r0_rsp_valid);
      end
   endtask

   task automatic test_zero();
      r1_valid = 1; r1_a = 7; r1_b = 7; r1_control = 3'b110;
      #1;
      n_tests++;
      if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin
         n_fail++; $display("FAIL zero_ready got=%b%b exp=10", r1_ready, r0_ready);
      end
      step();
      r1_valid = 0;
      step();
      n_tests++;
      if (r1_rsp_valid !== 1'b1 || r0_rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin
         n_fail++; $display("FAIL zero_rsp got rv=%b%b res=%0d z=%b exp 10 0 1", r1_rsp_valid, r0_rsp_valid, rsp_result, rsp_zero);
      end
      step();
   endtask

   task automatic test_contention();
      int grants[$];
      int exp_order[4] = '{0, 1, 0, 1};
      rst = 1'b1;
      step();
      rst = 1'b0;
      r0_valid = 1; r0_a = 1; r0_b = 1; r0_control = 3'b010;
      r1_valid = 1; r1_a = 1; r1_b = 1; r1_control = 3'b010;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (r0_ready) grants.push_back(0);
         if (r1_ready) grants.push_back(1);
         n_tests++;
         if ((r0_rsp_valid & r1_rsp_valid) !== 1'b0 || (r0_ready & r1_ready) !== 1'b0) begin
            n_fail++; $display("FAIL contention_exclusive cycle=%0d rv=%b%b rdy=%b%b", i, r1_rsp_valid, r0_rsp_valid, r1_ready, r0_ready);
         end
         if (r0_rsp_valid || r1_rsp_valid) begin
            n_tests++;
            if (rsp_result !== 32'd2) begin
               n_fail++; $display("FAIL contention_result cycle=%0d got=%0d exp=2", i, rsp_result);
            end
         end
         step();
      end
      r0_valid = 0; r1_valid = 0;
      n_tests++;
      if (grants.size() != 4) begin
         n_fail++; $display("FAIL contention_count got=%0d exp=4", grants.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (grants[i] != exp_order[i]) begin
               n_fail++; $display("FAIL contention_order idx=%0d got=%0d exp=%0d", i, grants[i], exp_order[i]);
            end
         end
      end
      step();
   endtask

   task automatic test_backpressure();
      r0_valid = 1; r0_a = 9; r0_b = 4; r0_control = 3'b110;
      r1_valid = 1; r1_a = 4; r1_b = 3; r1_control = 3'b001;
      r0_rsp_ready = 0;
      #1;
      n_tests++;
      if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_grant got=%b%b exp=01", r1_ready, r0_ready);
      end
      step();
      r0_valid = 0;
      step();
      n_tests++;
      if (r0_rsp_valid !== 1'b1 || rsp_result !== 32'd5) begin
         n_fail++; $display("FAIL bp_rsp got rv=%b res=%0d exp 1 5", r0_rsp_valid, rsp_result);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         n_tests++;
         if (r0_rsp_valid !== 1'b1 || rsp_result !== 32'd5 || r1_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold cycle=%0d rv=%b res=%0d r1rdy=%b exp 1 5 0", i, r0_rsp_valid, rsp_result, r1_ready);
         end
      end
      r0_rsp_ready = 1;
      #1;
      n_tests++;
      if (r1_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_no_early got=%b exp=0", r1_ready);
      end
      step();
      n_tests++;
      if (r0_rsp_valid !== 1'b0 || r1_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_release got rv=%b r1rdy=%b exp 0 1", r0_rsp_valid, r1_ready);
      end
      step();
      r1_valid = 0;
      step();
      n_tests++;
      if (r1_rsp_valid !== 1'b1 || r0_rsp_valid !== 1'b0 || rsp_result !== 32'd7) begin
         n_fail++; $display("FAIL bp_r1_rsp got rv=%b%b res=%0d exp 10 7", r1_rsp_valid, r0_rsp_valid, rsp_result);
      end
      step();
   endtask

   task automatic test_reset_mid_exec();
      int r0_seen = 0;
      r0_valid = 1; r0_a = 1; r0_b = 2; r0_control = 3'b010;
      step();
      r0_valid = 0;
      step();
      step();
      r0_valid = 1; r0_a = 20; r0_b = 6; r0_control = 3'b110;
      r1_valid = 1; r1_a = 3;  r1_b = 4; r1_control = 3'b001;
      #1;
      n_tests++;
      if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_grant got=%b%b exp=10", r1_ready, r0_ready);
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      n_tests++;
      if (r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0 || alu_control !== 3'b010 || alu_a !== 32'd0) begin
         n_fail++; $display("FAIL rstmid_state got rv=%b%b ctl=%b a=%0d exp 00 010 0", r1_rsp_valid, r0_rsp_valid, alu_control, alu_a);
      end
      n_tests++;
      if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_ptr got=%b%b exp=01", r1_ready, r0_ready);
      end
      r1_valid = 0;
      step();
      r0_valid = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_tests++;
         if (r1_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_dropped cycle=%0d r1_rsp_valid=%b exp=0", i, r1_rsp_valid);
         end
         if (r0_rsp_valid) begin
            r0_seen++;
            n_tests++;
            if (rsp_result !== 32'd14) begin
               n_fail++; $display("FAIL rstmid_r0_result got=%0d exp=14", rsp_result);
            end
         end
      end
      n_tests++;
      if (r0_seen != 1) begin
         n_fail++; $display("FAIL rstmid_r0_count got=%0d exp=1", r0_seen);
      end
   endtask

   task automatic test_opcheck();
      r0_valid = 1; r0_a = 11; r0_b = 22; r0_control = 3'b011;
      #1;
      n_tests++;
      if (r0_ready !== 1'b1) begin
         n_fail++; $display("FAIL op_ready got=%b exp=1", r0_ready);
      end
      step();
      r0_valid = 0;
`ifdef ALU_OPCHECK_EN
      n_tests++;
      if (r0_rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin
         n_fail++; $display("FAIL op_err_rsp got rv=%b err=%b res=%0d z=%b exp 1 1 0 0", r0_rsp_valid, rsp_err, rsp_result, rsp_zero);
      end
      n_tests++;
      if (alu_a !== 32'd20 || alu_b !== 32'd6 || alu_control !== 3'b110) begin
         n_fail++; $display("FAIL op_alu_hold got %0d/%0d/%b exp 20/6/110", alu_a, alu_b, alu_control);
      end
      step();
      r0_valid = 1; r0_a = 1; r0_b = 1; r0_control = 3'b111;
      step();
      r0_valid = 0;
      step();
      n_tests++;
      if (r0_rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin
         n_fail++; $display("FAIL op_legal_rsp got rv=%b err=%b res=%0d z=%b exp 1 0 0 1", r0_rsp_valid, rsp_err, rsp_result, rsp_zero);
      end
      step();
`else
      n_tests++;
      if (alu_control !== 3'b011 || alu_a !== 32'd11 || alu_b !== 32'd22 || r0_rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL op_forward got %0d/%0d/%b rv=%b exp 11/22/011 0", alu_a, alu_b, alu_control, r0_rsp_valid);
      end
      step();
      n_tests++;
      if (r0_rsp_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin
         n_fail++; $display("FAIL op_forward_rsp got rv=%b res=%0d z=%b exp 1 0 1", r0_rsp_valid, rsp_result, rsp_zero);
      end
      step();
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_zero();
      test_contention();
      test_backpressure();
      test_reset_mid_exec();
      test_opcheck();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
